// File: rtl/interface_ov7670_uc.sv
// Control unit for the OV7670 capture datapath: arms on iniciar, follows frame/line/byte
// pulses, strobes the pixel and quadrant counters and counts the stored 3x3 quadrant samples.
module interface_ov7670_uc #(
   parameter int LINES      = 140,
   parameter int N_AMOSTRAS = 9,
   parameter int TIMEOUT    = 2**20,
   parameter int S_TO       = 21
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       transmite_frame,
   input  logic       transmite_byte,
   input  logic       HREF,
   input  logic       pixel_armazenado,
   input  logic       fim_coluna_quadrante,
   output logic       zera_linha_pixel,
   output logic       zera_coluna_pixel,
   output logic       conta_linha_pixel,
   output logic       conta_coluna_pixel,
   output logic       zera_linha_quadrante,
   output logic       zera_coluna_quadrante,
   output logic       conta_linha_quadrante,
   output logic       conta_coluna_quadrante,
   output logic       byte_estavel,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARA       = 4'h1,
      ESPERA_FRAME  = 4'h2,
      ESPERA_LINHA  = 4'h3,
      ESPERA_BYTE1  = 4'h4,
      CAPTURA_BYTE1 = 4'h5,
      ESPERA_BYTE2  = 4'h6,
      CAPTURA_BYTE2 = 4'h7,
      ARMAZENA      = 4'h8,
      AVANCA_COLUNA = 4'h9,
      FIM_LINHA     = 4'hA,
      FIM           = 4'hB,
      ERRO          = 4'hC
   } estado_t;

   localparam int W_L = $clog2(LINES + 1);
   localparam int W_A = $clog2(N_AMOSTRAS + 1);
   localparam logic [S_TO-1:0] TO_MAX = S_TO'(TIMEOUT - 1);

   estado_t          state_q, state_d;
   logic [W_L-1:0]   n_linhas_q, n_linhas_d, n_linhas_inc;
   logic [W_A-1:0]   n_amostras_q, n_amostras_d, n_amostras_inc;
   logic [S_TO-1:0]  timeout_q, timeout_d;
   logic             href_meta_q, href_s_q;
   logic             timed_out;

   // HREF comes straight from the camera pins; only the second flop may feed the FSM.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         href_meta_q <= 1'b0;
         href_s_q    <= 1'b0;
      end else begin
         href_meta_q <= HREF;
         href_s_q    <= href_meta_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= INICIAL;
         n_linhas_q   <= '0;
         n_amostras_q <= '0;
         timeout_q    <= '0;
      end else begin
         state_q      <= state_d;
         n_linhas_q   <= n_linhas_d;
         n_amostras_q <= n_amostras_d;
         timeout_q    <= timeout_d;
      end
   end

   assign n_linhas_inc   = n_linhas_q + 1'b1;
   assign n_amostras_inc = n_amostras_q + 1'b1;
   assign timed_out      = (timeout_q == TO_MAX);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      n_linhas_d   = n_linhas_q;
      n_amostras_d = n_amostras_q;
      unique case (state_q)
         INICIAL:       if (iniciar) state_d = PREPARA;
         PREPARA: begin
            n_linhas_d   = '0;
            n_amostras_d = '0;
            state_d      = ESPERA_FRAME;
         end
         ESPERA_FRAME: begin
            if (transmite_frame) state_d = ESPERA_LINHA;
            else if (timed_out)  state_d = ERRO;
         end
         ESPERA_LINHA: begin
            if (transmite_frame) state_d = ERRO;
            else if (href_s_q)   state_d = ESPERA_BYTE1;
            else if (timed_out)  state_d = ERRO;
         end
         ESPERA_BYTE1: begin
            if (transmite_frame)     state_d = ERRO;
            else if (transmite_byte) state_d = CAPTURA_BYTE1;
            else if (!href_s_q)      state_d = FIM_LINHA;
            else if (timed_out)      state_d = ERRO;
         end
         CAPTURA_BYTE1: state_d = ESPERA_BYTE2;
         ESPERA_BYTE2: begin
            if (transmite_frame)     state_d = ERRO;
            else if (transmite_byte) state_d = CAPTURA_BYTE2;
            else if (!href_s_q)      state_d = FIM_LINHA;
            else if (timed_out)      state_d = ERRO;
         end
         CAPTURA_BYTE2: state_d = pixel_armazenado ? ARMAZENA : AVANCA_COLUNA;
         ARMAZENA: begin
            n_amostras_d = n_amostras_inc;
            state_d      = (n_amostras_inc == W_A'(N_AMOSTRAS)) ? FIM : AVANCA_COLUNA;
         end
         AVANCA_COLUNA: state_d = ESPERA_BYTE1;
         FIM_LINHA: begin
            n_linhas_d = n_linhas_inc;
            state_d    = (n_linhas_inc == W_L'(LINES)) ? ERRO : ESPERA_LINHA;
         end
         FIM, ERRO:     if (iniciar) state_d = PREPARA;
         default:       state_d = INICIAL;
      endcase
      // Time spent in the current state; saturates so idle states never wrap.
      if (state_d != state_q) timeout_d = '0;
      else if (timed_out)     timeout_d = timeout_q;
      else                    timeout_d = timeout_q + 1'b1;
   end

   always_comb begin
      zera_linha_pixel       = 1'b0;
      zera_coluna_pixel      = 1'b0;
      conta_linha_pixel      = 1'b0;
      conta_coluna_pixel     = 1'b0;
      zera_linha_quadrante   = 1'b0;
      zera_coluna_quadrante  = 1'b0;
      conta_linha_quadrante  = 1'b0;
      conta_coluna_quadrante = 1'b0;
      byte_estavel           = 1'b0;
      pronto                 = 1'b0;
      erro                   = 1'b0;
      unique case (state_q)
         PREPARA: begin
            zera_linha_pixel      = 1'b1;
            zera_coluna_pixel     = 1'b1;
            zera_linha_quadrante  = 1'b1;
            zera_coluna_quadrante = 1'b1;
         end
         CAPTURA_BYTE1, CAPTURA_BYTE2: byte_estavel = 1'b1;
         ARMAZENA: begin
            // Last quadrant column wraps to the next quadrant row.
            zera_coluna_quadrante  = fim_coluna_quadrante;
            conta_linha_quadrante  = fim_coluna_quadrante;
            conta_coluna_quadrante = !fim_coluna_quadrante;
         end
         AVANCA_COLUNA: conta_coluna_pixel = 1'b1;
         FIM_LINHA: begin
            conta_linha_pixel = 1'b1;
            zera_coluna_pixel = 1'b1;
         end
         FIM:     pronto = 1'b1;
         ERRO:    erro   = 1'b1;
         default: ;
      endcase
   end

   assign db_estado = state_q;

endmodule

// File: tb/tb_interface_ov7670_uc.sv
// Self-checking bench for interface_ov7670_uc: a datapath model answers the strobes, and an
// expected-strobe queue built from line/byte/match arithmetic is compared on every strobe cycle.
module tb_interface_ov7670_uc;

   localparam int LINES_T   = 12;
   localparam int N_AMOS_T  = 9;
   localparam int TIMEOUT_T = 300;
   localparam int S_TO_T    = 9;

   // Strobe vector: {zlp, zcp, clp, ccp, zlq, zcq, clq, ccq, byte_estavel}
   localparam logic [8:0] EV_PREP = 9'b110011000;
   localparam logic [8:0] EV_BYTE = 9'b000000001;
   localparam logic [8:0] EV_COL  = 9'b000100000;
   localparam logic [8:0] EV_LINE = 9'b011000000;
   localparam logic [8:0] EV_QCOL = 9'b000000010;
   localparam logic [8:0] EV_QROW = 9'b000001100;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0, transmite_frame = 1'b0, transmite_byte = 1'b0, HREF = 1'b0;
   logic       pixel_armazenado, fim_coluna_quadrante;
   logic       zera_linha_pixel, zera_coluna_pixel, conta_linha_pixel, conta_coluna_pixel;
   logic       zera_linha_quadrante, zera_coluna_quadrante, conta_linha_quadrante, conta_coluna_quadrante;
   logic       byte_estavel, pronto, erro;
   logic [3:0] db_estado;
   logic [8:0] strobes, obs_v;

   int n_checks = 0, n_fail = 0;
   int cnt_be = 0, cnt_ccp = 0, cnt_clp = 0, cnt_zcp = 0, cnt_st = 0;
   int s_be, s_ccp, s_clp, s_zcp, s_st;
   int lp, cp, lq, cq;
   int row_sel[3], col_sel[3];
   int m_k;
   bit m_done;
   logic [8:0] exp_q[$];

   interface_ov7670_uc #(
      .LINES(LINES_T), .N_AMOSTRAS(N_AMOS_T), .TIMEOUT(TIMEOUT_T), .S_TO(S_TO_T)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .transmite_frame(transmite_frame),
      .transmite_byte(transmite_byte), .HREF(HREF), .pixel_armazenado(pixel_armazenado),
      .fim_coluna_quadrante(fim_coluna_quadrante),
      .zera_linha_pixel(zera_linha_pixel), .zera_coluna_pixel(zera_coluna_pixel),
      .conta_linha_pixel(conta_linha_pixel), .conta_coluna_pixel(conta_coluna_pixel),
      .zera_linha_quadrante(zera_linha_quadrante), .zera_coluna_quadrante(zera_coluna_quadrante),
      .conta_linha_quadrante(conta_linha_quadrante), .conta_coluna_quadrante(conta_coluna_quadrante),
      .byte_estavel(byte_estavel), .pronto(pronto), .erro(erro), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   assign strobes = {zera_linha_pixel, zera_coluna_pixel, conta_linha_pixel, conta_coluna_pixel,
                     zera_linha_quadrante, zera_coluna_quadrante, conta_linha_quadrante,
                     conta_coluna_quadrante, byte_estavel};

   // Datapath model: pixel and quadrant counters driven by the DUT strobes.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         lp <= 0; cp <= 0; lq <= 0; cq <= 0;
      end else begin
         if (zera_linha_pixel) lp <= 0; else if (conta_linha_pixel) lp <= lp + 1;
         if (zera_coluna_pixel) cp <= 0; else if (conta_coluna_pixel) cp <= cp + 1;
         if (zera_linha_quadrante) lq <= 0; else if (conta_linha_quadrante) lq <= lq + 1;
         if (zera_coluna_quadrante) cq <= 0; else if (conta_coluna_quadrante) cq <= cq + 1;
      end
   end

   assign pixel_armazenado = byte_estavel
      && (lp == row_sel[0] || lp == row_sel[1] || lp == row_sel[2])
      && (cp == col_sel[0] || cp == col_sel[1] || cp == col_sel[2]);
   assign fim_coluna_quadrante = (cq == 2);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle with any strobe active must match the next expected strobe vector.
   always @(negedge clock) begin
      if (reset) begin
         obs_v = strobes;
         if (obs_v != 9'd0) begin
            if (obs_v[0]) cnt_be++;
            if (obs_v[5]) cnt_ccp++;
            if (obs_v[6]) cnt_clp++;
            if (obs_v[7]) cnt_zcp++;
            if (obs_v[1] || obs_v[2]) cnt_st++;
            if (exp_q.size() == 0) check("unexpected_strobe", 32'(obs_v), 32'd0);
            else                   check("strobe_seq", 32'(obs_v), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic bit is_row(input int r);
      return r == row_sel[0] || r == row_sel[1] || r == row_sel[2];
   endfunction

   function automatic bit is_col(input int c);
      return c == col_sel[0] || c == col_sel[1] || c == col_sel[2];
   endfunction

   // Reference: a line of nb bytes yields byte pulses, a column count per full pixel,
   // a quadrant store for matching pixels and a line-end strobe unless the capture completed.
   task automatic plan_line(input int r, input int nb);
      for (int b = 0; b < nb && !m_done; b++) begin
         exp_q.push_back(EV_BYTE);
         if (b % 2 == 1) begin
            if (is_row(r) && is_col(b / 2)) begin
               exp_q.push_back((m_k % 3 == 2) ? EV_QROW : EV_QCOL);
               m_k++;
               if (m_k == N_AMOS_T) m_done = 1'b1;
            end
            if (!m_done) exp_q.push_back(EV_COL);
         end
      end
      if (!m_done) exp_q.push_back(EV_LINE);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic snap();
      s_be = cnt_be; s_ccp = cnt_ccp; s_clp = cnt_clp; s_zcp = cnt_zcp; s_st = cnt_st;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      iniciar = 1'b0; transmite_frame = 1'b0; transmite_byte = 1'b0; HREF = 1'b0;
      exp_q.delete();
      wait_clk(3);
      check("reset_state", 32'(db_estado), 32'h0);
      check("reset_outputs", 32'({strobes, pronto, erro}), 32'h0);
      reset = 1'b1;
      wait_clk(1);
   endtask

   task automatic start_capture();
      m_k = 0;
      m_done = 1'b0;
      exp_q.push_back(EV_PREP);
      iniciar = 1'b1;
      wait_clk(1);
      iniciar = 1'b0;
   endtask

   task automatic send_frame();
      transmite_frame = 1'b1;
      wait_clk(1);
      transmite_frame = 1'b0;
   endtask

   task automatic send_line(input int nb, input int gap);
      int g;
      HREF = 1'b1;
      wait_clk(4);
      for (int b = 0; b < nb; b++) begin
         transmite_byte = 1'b1;
         wait_clk(1);
         transmite_byte = 1'b0;
         g = (gap != 0) ? gap : int'($urandom_range(5, 9));
         wait_clk(g - 1);
      end
      HREF = 1'b0;
      wait_clk(6);
   endtask

   task automatic run_capture(input int lo, input int hi);
      int nb;
      start_capture();
      wait_clk(1);
      send_frame();
      wait_clk(2);
      for (int r = 0; r < LINES_T; r++) begin
         nb = int'($urandom_range(hi, lo));
         plan_line(r, nb);
         send_line(nb, 0);
         if (m_done) break;
      end
      wait_clk(3);
      if (m_done) begin
         check("cap_pronto", 32'(pronto), 32'd1);
         check("cap_erro_low", 32'(erro), 32'd0);
         check("cap_state_fim", 32'(db_estado), 32'hB);
      end else begin
         check("cap_erro", 32'(erro), 32'd1);
         check("cap_pronto_low", 32'(pronto), 32'd0);
         check("cap_state_erro", 32'(db_estado), 32'hC);
      end
      check("cap_queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got time limit, expected end of test");
      $fatal(1, "bench time limit");
   end

   initial begin
      row_sel = '{100, 100, 100};
      col_sel = '{100, 100, 100};

      // Arming sequence and the single-cycle clear strobe.
      do_reset();
      m_k = 0; m_done = 1'b0;
      exp_q.push_back(EV_PREP);
      iniciar = 1'b1;
      check("arm_state0", 32'(db_estado), 32'h0);
      wait_clk(1);
      iniciar = 1'b0;
      check("arm_state1", 32'(db_estado), 32'h1);
      check("arm_zera_all", 32'({zera_linha_pixel, zera_coluna_pixel, zera_linha_quadrante,
                                  zera_coluna_quadrante}), 32'hF);
      wait_clk(1);
      check("arm_state2", 32'(db_estado), 32'h2);
      check("arm_zera_drop", 32'({zera_linha_pixel, zera_coluna_pixel, zera_linha_quadrante,
                                   zera_coluna_quadrante}), 32'h0);
      send_frame();
      check("frame_to_linha", 32'(db_estado), 32'h3);
      wait_clk(1);

      // Four bytes 8 clocks apart, then a line ending on a half pixel.
      snap();
      plan_line(0, 4);
      send_line(4, 8);
      check("line4_bytes", 32'(cnt_be - s_be), 32'd4);
      check("line4_cols", 32'(cnt_ccp - s_ccp), 32'd2);
      check("line4_lines", 32'(cnt_clp - s_clp), 32'd1);
      snap();
      plan_line(1, 3);
      send_line(3, 8);
      check("line3_bytes", 32'(cnt_be - s_be), 32'd3);
      check("line3_cols", 32'(cnt_ccp - s_ccp), 32'd1);
      check("line3_lines", 32'(cnt_clp - s_clp), 32'd1);
      check("line3_zera_col", 32'(cnt_zcp - s_zcp), 32'd1);

      // A new frame while waiting for a line aborts; iniciar re-arms.
      send_frame();
      check("early_frame_erro", 32'(erro), 32'd1);
      check("early_frame_state", 32'(db_estado), 32'hC);
      exp_q.push_back(EV_PREP);
      iniciar = 1'b1;
      wait_clk(1);
      iniciar = 1'b0;
      check("rearm_state", 32'(db_estado), 32'h1);
      check("rearm_erro_drop", 32'(erro), 32'd0);
      wait_clk(2);
      check("rearm_queue", 32'(exp_q.size()), 32'd0);

      // Full 3x3 capture with fixed 12-byte lines: hand-computed totals.
      do_reset();
      row_sel = '{2, 5, 8};
      col_sel = '{1, 3, 5};
      snap();
      run_capture(12, 12);
      check("full_stores", 32'(cnt_st - s_st), 32'd9);
      check("full_lines", 32'(cnt_clp - s_clp), 32'd8);
      check("full_cols", 32'(cnt_ccp - s_ccp), 32'd53);
      check("full_bytes", 32'(cnt_be - s_be), 32'd108);
      check("full_quad_row", 32'(lq), 32'd3);
      check("full_quad_col", 32'(cq), 32'd0);

      // Only two quadrant rows inside the window: short frame ends in ERRO.
      do_reset();
      row_sel = '{2, 5, 20};
      col_sel = '{1, 3, 5};
      snap();
      run_capture(12, 20);
      check("short_stores", 32'(cnt_st - s_st), 32'd6);
      check("short_lines", 32'(cnt_clp - s_clp), 32'(LINES_T));

      // No frame pulse: timeout in ESPERA_FRAME.
      do_reset();
      start_capture();
      wait_clk(TIMEOUT_T - 5);
      check("to_still_waiting", 32'(db_estado), 32'h2);
      wait_clk(10);
      check("to_erro", 32'(erro), 32'd1);
      check("to_state", 32'(db_estado), 32'hC);
      exp_q.push_back(EV_PREP);
      iniciar = 1'b1;
      wait_clk(1);
      iniciar = 1'b0;
      check("to_rearm_state", 32'(db_estado), 32'h1);
      check("to_rearm_erro", 32'(erro), 32'd0);

      // Reset asserted while in CAPTURA_BYTE2 clears everything at once.
      do_reset();
      row_sel = '{0, 1, 2};
      col_sel = '{0, 1, 2};
      start_capture();
      wait_clk(1);
      send_frame();
      wait_clk(2);
      HREF = 1'b1;
      wait_clk(4);
      exp_q.push_back(EV_BYTE);
      transmite_byte = 1'b1;
      wait_clk(1);
      transmite_byte = 1'b0;
      wait_clk(4);
      transmite_byte = 1'b1;
      wait_clk(1);
      check("cb2_state", 32'(db_estado), 32'h7);
      check("cb2_byte_estavel", 32'(byte_estavel), 32'd1);
      reset = 1'b0;
      transmite_byte = 1'b0;
      #1;
      check("mid_reset_state", 32'(db_estado), 32'h0);
      check("mid_reset_outputs", 32'({strobes, pronto, erro}), 32'h0);
      HREF = 1'b0;
      exp_q.delete();
      wait_clk(2);

      // Randomized captures: random quadrant positions and line lengths.
      for (int t = 0; t < 4; t++) begin
         do_reset();
         row_sel[0] = int'($urandom_range(3, 0));
         row_sel[1] = row_sel[0] + int'($urandom_range(4, 1));
         row_sel[2] = row_sel[1] + int'($urandom_range(5, 1));
         col_sel[0] = int'($urandom_range(2, 0));
         col_sel[1] = col_sel[0] + int'($urandom_range(3, 1));
         col_sel[2] = col_sel[1] + int'($urandom_range(3, 1));
         run_capture(11, 20);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
